// File: rtl/shift_unit_seq_pkg.sv
// Shared codes for the multi-cycle shift unit: operation modes and FSM states.
// ALU control decode imports the same mode encoding.
package shift_unit_seq_pkg;

    typedef enum logic [1:0] {
        SH_SLL  = 2'b00,
        SH_SRL  = 2'b01,
        SH_SRA  = 2'b10,
        SH_ROTR = 2'b11
    } sh_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } sh_state_e;

endpackage

// File: rtl/shift_unit_seq_step.sv
// One combinational shift step of 0..STEP positions in any of the four modes.
// Each candidate amount is a constant shift; k selects among them.
module shift_step
    import shift_unit_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    localparam int KW   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [KW-1:0]    k,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] y
);

    logic [STEP:0][WIDTH-1:0] cand;

    for (genvar gi = 0; gi <= STEP; gi++) begin : g_cand
        if (gi == 0) begin : g_zero
            assign cand[gi] = a;
        end else begin : g_amt
            logic [WIDTH-1:0] c;
            always_comb begin
                case (mode)
                    SH_SLL:  c = a << gi;
                    SH_SRL:  c = a >> gi;
                    SH_SRA:  c = WIDTH'($signed(a) >>> gi);
                    default: c = (a >> gi) | (a << (WIDTH - gi));
                endcase
            end
            assign cand[gi] = c;
        end
    end

    always_comb begin
        y = cand[0];
        for (int i = 1; i <= STEP; i++) begin
            if (k == KW'(i)) y = cand[i];
        end
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shift unit: accepts an operand, shifts up to STEP bits per clock,
// then presents the result under valid/ready until the consumer takes it.
module shift_unit_seq
    import shift_unit_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int KW = $clog2(STEP + 1);

    sh_state_e        state_q, state_d;
    sh_mode_e         mode_q, mode_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [SHW-1:0]   rem_q, rem_d;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] step_y;

    always_comb begin
        if (32'(rem_q) > STEP) k = KW'(STEP);
        else                   k = KW'(rem_q);
    end

    shift_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
        .a    (acc_q),
        .k    (k),
        .mode (mode_q),
        .y    (step_y)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        res_d   = res_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    acc_d  = in_data;
                    rem_d  = in_shamt;
                    mode_d = sh_mode_e'(in_mode);
                    if (in_shamt == '0) begin
                        state_d = ST_DONE;
                        res_d   = in_data;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                acc_d = step_y;
                rem_d = rem_q - SHW'(k);
                if (rem_d == '0) begin
                    state_d = ST_DONE;
                    res_d   = step_y;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= SH_SLL;
            acc_q   <= '0;
            res_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            rem_q   <= rem_d;
        end
    end

    // in_ready is masked by rst so nothing looks acceptable while reset is held
    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = res_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed and randomised checks of shift_unit_seq (WIDTH=32, STEP=4) against a
// single-cycle reference shift, including latency, stall and mid-operation reset.
module tb_shift_unit_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int total = 0;
    int bad   = 0;

    shift_unit_seq #(.WIDTH(32), .STEP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic [1:0] m);
        case (m)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return 32'($signed(d) >>> s);
            default: return (s == 0) ? d : ((d >> s) | (d << (32 - s)));
        endcase
    endfunction

    // Issue one op, measure edges from accept to out_valid, hold off out_ready for
    // 'stall' cycles, then retire it.
    task automatic run_op(input string tag, input logic [31:0] d, input int s,
                          input logic [1:0] m, input logic [31:0] exp, input int stall);
        int lat;
        int exp_lat;
        exp_lat = (s + 3) / 4;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = 5'(s);
        in_mode  = m;
        tick();
        in_valid = 1'b0;
        in_data  = $urandom;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_data"}, out_data, exp);
        for (int i = 0; i < stall; i++) begin
            tick();
            if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0)
                chk({tag, "_stall_hold"}, {out_valid, in_ready, out_data[29:0]}, {1'b1, 1'b0, exp[29:0]});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_retire"}, 32'(out_valid), 32'd0);
        $display("op %s: d=%h shamt=%0d mode=%0d -> %h lat=%0d", tag, d, s, m, out_data, lat);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_mode   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        tick();

        run_op("sll_legacy", 32'h0000_0001, 2, 2'b00, 32'h0000_0004, 0);
        run_op("sra_31", 32'h8000_0000, 31, 2'b10, 32'hFFFF_FFFF, 0);
        run_op("srl_31", 32'h8000_0000, 31, 2'b01, 32'h0000_0001, 0);
        run_op("rotr_4", 32'h0000_00F1, 4, 2'b11, 32'h1000_000F, 0);
        run_op("rotr_5", 32'h0000_0003, 5, 2'b11, 32'h1800_0000, 1);
        run_op("sra_pos", 32'h7000_0000, 7, 2'b10, 32'h00E0_0000, 0);

        // shamt 0: result on the accept edge, held through a 5-cycle out_ready stall
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        in_shamt = 5'd0;
        in_mode  = 2'b00;
        tick();
        in_data  = 32'h1234_5678;
        in_shamt = 5'd3;
        chk("z_valid_on_accept", 32'(out_valid), 32'd1);
        chk("z_data", out_data, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("z_hold_valid", 32'(out_valid), 32'd1);
            chk("z_hold_data", out_data, 32'hDEAD_BEEF);
            chk("z_hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("z_retire_valid", 32'(out_valid), 32'd0);
        chk("z_retire_busy", 32'(busy), 32'd0);
        chk("z_keep_data", out_data, 32'hDEAD_BEEF);
        $display("op shamt0_stall: d=deadbeef -> %h", out_data);

        // reset during SHIFT discards the operation
        in_valid = 1'b1;
        in_data  = 32'h0000_0001;
        in_shamt = 5'd20;
        in_mode  = 2'b00;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("mid_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", out_data, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("mid_rst_no_result", 32'(seen), 32'd0);
        $display("op reset_mid_shift: discarded");
        run_op("after_rst", 32'hF000_0000, 28, 2'b01, 32'h0000_000F, 0);

        // random ops with idle gaps and out_ready stalls
        for (int n = 0; n < 300; n++) begin
            logic [31:0] d;
            int s;
            logic [1:0] m;
            int gap;
            d   = $urandom;
            s   = $urandom_range(0, 31);
            m   = 2'($urandom_range(0, 3));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
            run_op($sformatf("rnd%0d", n), d, s, m, ref_shift(d, s, m), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
